// File: rtl/points_uart_tx.sv
// Per-frame point snapshot serialiser: on each VGA_VS falling edge, latch up to four
// points and stream them as a fixed 20-byte UART 8N1 packet with a trailing checksum.
module points_uart_tx #(
  parameter int CLK_FREQ     = 50000000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        VGA_VS,
  input  logic [15:0] i_POINTS_H_0,
  input  logic [15:0] i_POINTS_H_1,
  input  logic [15:0] i_POINTS_H_2,
  input  logic [15:0] i_POINTS_H_3,
  input  logic [15:0] i_POINTS_V_0,
  input  logic [15:0] i_POINTS_V_1,
  input  logic [15:0] i_POINTS_V_2,
  input  logic [15:0] i_POINTS_V_3,
  input  logic [2:0]  i_POINT_COUNT,
  output logic        o_UART_TX,
  output logic        o_BUSY,
  output logic [7:0]  o_DROP_CNT
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [4:0] LAST_BYTE = 5'd19;
  localparam logic [7:0] HDR0 = 8'hA5;
  localparam logic [7:0] HDR1 = 8'h5A;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_reg;
  logic             rvs_reg;
  logic             eof;
  logic [2:0]       count_clamped;
  logic [2:0]       count_reg;
  logic [15:0]      pts_h [4];
  logic [15:0]      pts_v [4];
  logic [15:0]      snap_h [4];
  logic [15:0]      snap_v [4];
  logic [15:0]      h_reg [4];
  logic [15:0]      v_reg [4];
  logic [CNT_W-1:0] bit_cnt_reg;
  logic [2:0]       bit_idx_reg;
  logic [4:0]       byte_idx_reg;
  logic [7:0]       shift_reg;
  logic [7:0]       csum_reg;
  logic             tx_reg;
  logic             busy_reg;
  logic [7:0]       drop_reg;

  logic             bit_done;
  logic [4:0]       next_idx;
  logic [3:0]       off;
  logic [15:0]      sel_h;
  logic [15:0]      sel_v;
  logic [7:0]       next_byte;
  logic             csum_add;

  assign pts_h[0] = i_POINTS_H_0;
  assign pts_h[1] = i_POINTS_H_1;
  assign pts_h[2] = i_POINTS_H_2;
  assign pts_h[3] = i_POINTS_H_3;
  assign pts_v[0] = i_POINTS_V_0;
  assign pts_v[1] = i_POINTS_V_1;
  assign pts_v[2] = i_POINTS_V_2;
  assign pts_v[3] = i_POINTS_V_3;

  assign eof           = rvs_reg & ~VGA_VS;
  assign count_clamped = (i_POINT_COUNT > 3'd4) ? 3'd4 : i_POINT_COUNT;

  // Slots beyond the valid count are zeroed so stale coordinates never leak out.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_snap
      assign snap_h[gi] = (3'(gi) < count_clamped) ? pts_h[gi] : 16'h0000;
      assign snap_v[gi] = (3'(gi) < count_clamped) ? pts_v[gi] : 16'h0000;
    end
  endgenerate

  assign bit_done = (bit_cnt_reg == BIT_LAST);
  assign next_idx = byte_idx_reg + 5'd1;
  // Coordinate bytes start at index 3: off[3:2] picks the point, off[1:0] the byte.
  assign off      = next_idx[3:0] - 4'd3;
  assign sel_h    = h_reg[off[3:2]];
  assign sel_v    = v_reg[off[3:2]];
  assign csum_add = (next_idx >= 5'd2) && (next_idx <= 5'd18);

  always_comb begin
    next_byte = 8'h00;
    if (next_idx == 5'd1) begin
      next_byte = HDR1;
    end else if (next_idx == 5'd2) begin
      next_byte = {5'd0, count_reg};
    end else if (next_idx == LAST_BYTE) begin
      next_byte = csum_reg;
    end else begin
      case (off[1:0])
        2'd0:    next_byte = sel_h[15:8];
        2'd1:    next_byte = sel_h[7:0];
        2'd2:    next_byte = sel_v[15:8];
        default: next_byte = sel_v[7:0];
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg    <= IDLE;
      rvs_reg      <= 1'b0;
      count_reg    <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        h_reg[i] <= 16'h0000;
        v_reg[i] <= 16'h0000;
      end
      bit_cnt_reg  <= '0;
      bit_idx_reg  <= 3'd0;
      byte_idx_reg <= 5'd0;
      shift_reg    <= 8'h00;
      csum_reg     <= 8'h00;
      tx_reg       <= 1'b1;
      busy_reg     <= 1'b0;
      drop_reg     <= 8'h00;
    end else begin
      rvs_reg <= VGA_VS;

      if (eof && (state_reg != IDLE) && (drop_reg != 8'hFF)) begin
        drop_reg <= drop_reg + 8'd1;
      end

      case (state_reg)
        IDLE: begin
          if (eof) begin
            count_reg <= count_clamped;
            for (int i = 0; i < 4; i++) begin
              h_reg[i] <= snap_h[i];
              v_reg[i] <= snap_v[i];
            end
            shift_reg    <= HDR0;
            byte_idx_reg <= 5'd0;
            bit_cnt_reg  <= '0;
            bit_idx_reg  <= 3'd0;
            csum_reg     <= 8'h00;
            tx_reg       <= 1'b0;
            busy_reg     <= 1'b1;
            state_reg    <= START;
          end
        end

        START: begin
          if (bit_done) begin
            bit_cnt_reg <= '0;
            bit_idx_reg <= 3'd0;
            tx_reg      <= shift_reg[0];
            state_reg   <= DATA;
          end else begin
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
          end
        end

        DATA: begin
          if (bit_done) begin
            bit_cnt_reg <= '0;
            if (bit_idx_reg == 3'd7) begin
              tx_reg    <= 1'b1;
              state_reg <= STOP;
            end else begin
              bit_idx_reg <= bit_idx_reg + 3'd1;
              tx_reg      <= shift_reg[1];
              shift_reg   <= {1'b0, shift_reg[7:1]};
            end
          end else begin
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
          end
        end

        STOP: begin
          if (bit_done) begin
            bit_cnt_reg <= '0;
            if (byte_idx_reg == LAST_BYTE) begin
              tx_reg    <= 1'b1;
              busy_reg  <= 1'b0;
              state_reg <= IDLE;
            end else begin
              byte_idx_reg <= next_idx;
              shift_reg    <= next_byte;
              if (csum_add) begin
                csum_reg <= csum_reg + next_byte;
              end
              tx_reg    <= 1'b0;
              state_reg <= START;
            end
          end else begin
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
          end
        end

        default: begin
          tx_reg    <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign o_UART_TX  = tx_reg;
  assign o_BUSY     = busy_reg;
  assign o_DROP_CNT = drop_reg;

endmodule
